// File: rtl/beamformer_pkg.sv
// Shared types for the beam sequencer: table entry layout and FSM states.
package beamformer_pkg;

   localparam int BEAM_ENTRY_W = 33;
   localparam int WAIT_CNT_W   = 13;

   typedef struct packed {
      logic        isTX;
      logic [15:0] el;
      logic [15:0] az;
   } beam_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_DWELL
   } seq_state_e;

endpackage

// File: rtl/beam_table_ram.sv
// Beam table: 1 write / 1 registered read port. A same-cycle write to the
// entry being read returns the old contents (read sees pre-edge array).
module beam_table_ram
   import beamformer_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wen,
   input  logic [AW-1:0] waddr,
   input  beam_entry_t   wdata,
   input  logic          ren,
   input  logic [AW-1:0] raddr,
   output beam_entry_t   rdata
);

   beam_entry_t mem [DEPTH];
   beam_entry_t rdata_q;
   beam_entry_t rdata_d;

   // read data only moves on a read strobe so the units see a stable entry
   always_comb begin
      rdata_d = rdata_q;
      if (ren) rdata_d = mem[raddr];
   end

   // array storage; no reset, software rewrites the table after reset
   always_ff @(posedge clk) begin
      if (wen) mem[waddr] <= wdata;
   end

   // output register cleared by reset so the beam outputs start at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/beam_sequencer.sv
// Beam sequencer: walks the beam table, starts the calc units, collects their
// done flags (with timeout), dwells, and advances / loops / finishes.
module beam_sequencer
   import beamformer_pkg::*;
#(
   parameter int NUM_UNITS = 8,
   parameter int TBL_DEPTH = 64,
   parameter int TBL_AW    = 6,
   parameter int TIMEOUT   = 4096,
   parameter int DWELL_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tbl_wen,
   input  logic [TBL_AW-1:0]       tbl_waddr,
   input  logic [BEAM_ENTRY_W-1:0] tbl_wdata,
   input  logic                    run,
   input  logic                    abort,
   input  logic [TBL_AW:0]         beam_count,
   input  logic                    loop_en,
   input  logic [DWELL_W-1:0]      dwell_cycles,
   input  logic [NUM_UNITS-1:0]    bf_done,
   output logic                    bf_start,
   output logic [15:0]             bf_az,
   output logic [15:0]             bf_el,
   output logic                    bf_isTX,
   output logic                    busy,
   output logic [TBL_AW-1:0]       beam_idx,
   output logic                    beam_done,
   output logic                    seq_done,
   output logic                    timeout_err,
   output logic [NUM_UNITS-1:0]    timeout_mask
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

   seq_state_e              state_q, state_d;
   logic [TBL_AW-1:0]       beam_idx_q, beam_idx_d;
   logic [TBL_AW:0]         count_q, count_d;
   logic [NUM_UNITS-1:0]    collect_q, collect_d;
   logic [WAIT_CNT_W-1:0]   wait_q, wait_d;
   logic [DWELL_W-1:0]      dwell_q, dwell_d;
   logic                    err_q, err_d;
   logic [NUM_UNITS-1:0]    mask_q, mask_d;
   logic                    seq_done_q, seq_done_d;
   logic                    beam_done_c;
   logic                    ram_ren;
   logic                    last_beam;
   logic [NUM_UNITS-1:0]    all_done;
   beam_entry_t             wentry;
   beam_entry_t             entry;

   assign wentry = tbl_wdata;

   beam_table_ram #(.DEPTH(TBL_DEPTH), .AW(TBL_AW)) u_tbl (
      .clk   (clk),
      .rst   (rst),
      .wen   (tbl_wen),
      .waddr (tbl_waddr),
      .wdata (wentry),
      .ren   (ram_ren),
      .raddr (beam_idx_q),
      .rdata (entry)
   );

   // next-state, counters and done collection; abort overrides everything
   always_comb begin
      state_d     = state_q;
      beam_idx_d  = beam_idx_q;
      count_d     = count_q;
      collect_d   = collect_q;
      wait_d      = wait_q;
      dwell_d     = dwell_q;
      err_d       = err_q;
      mask_d      = mask_q;
      seq_done_d  = 1'b0;
      beam_done_c = 1'b0;
      ram_ren     = 1'b0;
      all_done    = collect_q | bf_done;
      last_beam   = ({1'b0, beam_idx_q} == (count_q - (TBL_AW+1)'(1)));
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run) begin
                  if (beam_count != '0) begin
                     beam_idx_d = '0;
                     count_d    = beam_count;
                     err_d      = 1'b0;
                     mask_d     = '0;
                     state_d    = ST_LOAD;
                  end else begin
                     seq_done_d = 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               ram_ren = 1'b1;
               state_d = ST_START;
            end
            ST_START: begin
               collect_d = '0;
               wait_d    = '0;
               state_d   = ST_WAIT;
            end
            ST_WAIT: begin
               collect_d = all_done;
               if (&all_done || wait_q == WAIT_LAST) begin
                  beam_done_c = 1'b1;
                  dwell_d     = dwell_cycles;
                  state_d     = ST_DWELL;
                  if (!(&all_done)) begin
                     err_d  = 1'b1;
                     mask_d = ~all_done;
                  end
               end else if (wait_q != '1) begin
                  wait_d = wait_q + WAIT_CNT_W'(1);
               end
            end
            ST_DWELL: begin
               if (dwell_q != '0) begin
                  dwell_d = dwell_q - DWELL_W'(1);
               end else if (last_beam) begin
                  if (loop_en) begin
                     beam_idx_d = '0;
                     state_d    = ST_LOAD;
                  end else begin
                     seq_done_d = 1'b1;
                     state_d    = ST_IDLE;
                  end
               end else begin
                  beam_idx_d = beam_idx_q + TBL_AW'(1);
                  state_d    = ST_LOAD;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // state and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         beam_idx_q <= '0;
         count_q    <= '0;
         collect_q  <= '0;
         wait_q     <= '0;
         dwell_q    <= '0;
         err_q      <= 1'b0;
         mask_q     <= '0;
         seq_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         beam_idx_q <= beam_idx_d;
         count_q    <= count_d;
         collect_q  <= collect_d;
         wait_q     <= wait_d;
         dwell_q    <= dwell_d;
         err_q      <= err_d;
         mask_q     <= mask_d;
         seq_done_q <= seq_done_d;
      end
   end

   // beam_done fires in the WAIT cycle that completes the beam
   assign bf_start     = (state_q == ST_START);
   assign busy         = (state_q != ST_IDLE);
   assign beam_idx     = beam_idx_q;
   assign beam_done    = beam_done_c;
   assign seq_done     = seq_done_q;
   assign timeout_err  = err_q;
   assign timeout_mask = mask_q;
   assign bf_az        = entry.az;
   assign bf_el        = entry.el;
   assign bf_isTX      = entry.isTX;

endmodule

// File: tb/tb_beam_sequencer.sv
// Self-checking bench for beam_sequencer: cycle-level behavioural model plus
// directed scenarios with hand-computed expectations, then randomized runs.
module tb_beam_sequencer;

   localparam int NU    = 8;
   localparam int AW    = 6;
   localparam int DEPTH = 64;
   localparam int TMO   = 16;
   localparam int DW    = 16;
   localparam int NEVER = 100000;
   localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_WAIT = 3, P_DWELL = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tbl_wen = 1'b0;
   logic [AW-1:0] tbl_waddr = '0;
   logic [32:0]   tbl_wdata = '0;
   logic          run = 1'b0;
   logic          abort = 1'b0;
   logic [AW:0]   beam_count = '0;
   logic          loop_en = 1'b0;
   logic [DW-1:0] dwell_cycles = '0;
   logic [NU-1:0] bf_done = '0;
   logic          bf_start, bf_isTX, busy, beam_done, seq_done, timeout_err;
   logic [15:0]   bf_az, bf_el;
   logic [AW-1:0] beam_idx;
   logic [NU-1:0] timeout_mask;

   always #5 clk = ~clk;

   beam_sequencer #(.NUM_UNITS(NU), .TBL_DEPTH(DEPTH), .TBL_AW(AW),
                    .TIMEOUT(TMO), .DWELL_W(DW)) dut (
      .clk(clk), .rst(rst), .tbl_wen(tbl_wen), .tbl_waddr(tbl_waddr),
      .tbl_wdata(tbl_wdata), .run(run), .abort(abort), .beam_count(beam_count),
      .loop_en(loop_en), .dwell_cycles(dwell_cycles), .bf_done(bf_done),
      .bf_start(bf_start), .bf_az(bf_az), .bf_el(bf_el), .bf_isTX(bf_isTX),
      .busy(busy), .beam_idx(beam_idx), .beam_done(beam_done), .seq_done(seq_done),
      .timeout_err(timeout_err), .timeout_mask(timeout_mask)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- calc-unit responder ----------------
   // Unit u answers dly[u] cycles after the bf_start cycle (0 = in START itself).
   int dly [NU];
   bit lvl = 0;
   int since = NEVER;
   always @(posedge clk) begin
      #1;
      if (bf_start === 1'b1) since = 0;
      else if (since < NEVER) since++;
      for (int u = 0; u < NU; u++)
         bf_done[u] = (dly[u] < NEVER) && (lvl ? (since >= dly[u]) : (since == dly[u]));
   end

   // ---------------- behavioural model ----------------
   int          m_ph, m_idx, m_cnt, m_wt, m_dw;
   logic [NU-1:0] m_got, m_mask;
   logic        m_err, m_sd, m_tx;
   logic [15:0] m_el, m_az;
   logic [32:0] m_tbl [DEPTH];

   task automatic model_reset();
      m_ph = P_IDLE; m_idx = 0; m_cnt = 0; m_wt = 0; m_dw = 0;
      m_got = '0; m_mask = '0; m_err = 0; m_sd = 0; m_tx = 0; m_el = '0; m_az = '0;
   endtask

   // beam ends this cycle: every unit seen since START, or TMO wait cycles used
   function automatic bit wait_exit();
      return (m_ph == P_WAIT) && !abort &&
             (((m_got | bf_done) == {NU{1'b1}}) || (m_wt + 1 >= TMO));
   endfunction

   task automatic model_step();
      bit ex;
      ex = wait_exit();
      m_sd = 0;
      if (abort) m_ph = P_IDLE;
      else case (m_ph)
         P_IDLE: if (run) begin
            if (beam_count != 0) begin
               m_idx = 0; m_cnt = int'(beam_count); m_err = 0; m_mask = '0; m_ph = P_LOAD;
            end else m_sd = 1;
         end
         P_LOAD:  begin {m_tx, m_el, m_az} = m_tbl[m_idx]; m_ph = P_START; end
         P_START: begin m_got = '0; m_wt = 0; m_ph = P_WAIT; end
         P_WAIT: begin
            m_got = m_got | bf_done;
            m_wt++;
            if (ex) begin
               if (m_got != {NU{1'b1}}) begin m_err = 1; m_mask = ~m_got; end
               m_dw = int'(dwell_cycles);
               m_ph = P_DWELL;
            end
         end
         P_DWELL: begin
            if (m_dw > 0) m_dw--;
            else if (m_idx == m_cnt - 1) begin
               if (loop_en) begin m_idx = 0; m_ph = P_LOAD; end
               else begin m_sd = 1; m_ph = P_IDLE; end
            end else begin m_idx++; m_ph = P_LOAD; end
         end
         default: m_ph = P_IDLE;
      endcase
      if (tbl_wen) m_tbl[tbl_waddr] = tbl_wdata;
   endtask

   // ---------------- compare + event recording ----------------
   int n_start = 0, n_bd = 0, n_sd = 0, cyc = 0, last_start = 0;
   int az_q[$], idx_q[$], dist_q[$];

   always @(posedge clk) begin
      logic [51:0] act, exp;
      if (!rst) model_step();
      #2;
      if (rst) model_reset();
      act = {bf_start, busy, beam_idx, beam_done, seq_done, timeout_err,
             timeout_mask, bf_isTX, bf_el, bf_az};
      exp = {m_ph == P_START, m_ph != P_IDLE, AW'(m_idx), wait_exit(), m_sd, m_err,
             m_mask, m_tx, m_el, m_az};
      chk("cycle_outputs", 64'(act), 64'(exp));
      if (bf_start === 1'b1) begin
         n_start++; az_q.push_back(int'(bf_az)); idx_q.push_back(int'(beam_idx));
         last_start = cyc;
      end
      if (beam_done === 1'b1) begin n_bd++; dist_q.push_back(cyc - last_start); end
      if (seq_done === 1'b1) n_sd++;
      cyc++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      n_start = 0; n_bd = 0; n_sd = 0;
      az_q.delete(); idx_q.delete(); dist_q.delete();
   endtask

   task automatic set_dly(input int d);
      for (int u = 0; u < NU; u++) dly[u] = d;
   endtask

   task automatic write_table();
      for (int i = 0; i < DEPTH; i++) begin
         tbl_wen = 1; tbl_waddr = AW'(i);
         tbl_wdata = {1'(i % 2), 16'(i * 3), 16'(10 * (i + 1))};
         tick();
      end
      tbl_wen = 0;
   endtask

   task automatic start_run(input int cnt, input int dwell, input bit lp);
      beam_count = (AW+1)'(cnt); dwell_cycles = DW'(dwell); loop_en = lp;
      run = 1; tick(); run = 0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin tick(); n++; end
      chk(name, 64'(busy), 64'(0));
   endtask

   // ---------------- directed + random scenarios ----------------
   initial begin
      set_dly(NEVER);
      repeat (3) tick();
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_idx", 64'(beam_idx), 64'(0));
      rst = 0;
      tick();
      write_table();

      // reset in the middle of WAIT
      start_run(1, 0, 0);
      repeat (4) tick();
      rst = 1;
      #1;
      chk("rst_wait_busy", 64'(busy), 64'(0));
      chk("rst_wait_outs", 64'({bf_start, beam_done, seq_done, timeout_err, timeout_mask}), 64'(0));
      chk("rst_wait_beam", 64'({bf_isTX, bf_el, bf_az, beam_idx}), 64'(0));
      tick(); tick();
      rst = 0;
      tick();
      write_table();

      // basic 3-beam pass
      clr(); set_dly(5);
      start_run(3, 2, 0);
      wait_idle("basic_idle", 200);
      tick();
      chk("basic_starts", 64'(n_start), 64'(3));
      chk("basic_az0", 64'(az_q[0]), 64'(10));
      chk("basic_az1", 64'(az_q[1]), 64'(20));
      chk("basic_az2", 64'(az_q[2]), 64'(30));
      chk("basic_beam_done", 64'(n_bd), 64'(3));
      chk("basic_seq_done", 64'(n_sd), 64'(1));
      chk("basic_wait_len", 64'(dist_q[0]), 64'(5));

      // unit 5 never answers -> timeout
      clr(); set_dly(3); dly[5] = NEVER;
      start_run(2, 0, 0);
      wait_idle("tmo_idle", 200);
      tick();
      chk("tmo_starts", 64'(n_start), 64'(2));
      chk("tmo_dist", 64'(dist_q[0]), 64'(16));
      chk("tmo_err", 64'(timeout_err), 64'(1));
      chk("tmo_mask", 64'(timeout_mask), 64'(8'h20));

      // loop with abort in the third beam's WAIT
      clr(); set_dly(4);
      start_run(2, 1, 1);
      chk("loop_err_cleared", 64'(timeout_err), 64'(0));
      begin
         int n = 0;
         while (n_start < 3 && n < 200) begin tick(); n++; end
         chk("loop_third_start", 64'(n_start), 64'(3));
      end
      abort = 1; tick(); abort = 0;
      chk("abort_idle", 64'(busy), 64'(0));
      tick();
      chk("loop_idx0", 64'(idx_q[0]), 64'(0));
      chk("loop_idx1", 64'(idx_q[1]), 64'(1));
      chk("loop_idx2", 64'(idx_q[2]), 64'(0));
      chk("loop_no_seq_done", 64'(n_sd), 64'(0));
      chk("abort_no_beam_done", 64'(n_bd), 64'(2));

      // beam_count = 0
      clr();
      start_run(0, 0, 0);
      chk("zero_seq_done", 64'(seq_done), 64'(1));
      chk("zero_busy", 64'(busy), 64'(0));
      repeat (5) tick();
      chk("zero_no_start", 64'(n_start), 64'(0));

      // beam_count = 64 full table
      clr(); set_dly(1);
      start_run(64, 0, 0);
      wait_idle("full_idle", 400);
      tick();
      chk("full_starts", 64'(n_start), 64'(64));
      chk("full_last_idx", 64'(idx_q[63]), 64'(63));
      chk("full_last_az", 64'(az_q[63]), 64'(640));
      chk("full_seq_done", 64'(n_sd), 64'(1));

      // staggered done pulses: last unit arrives 9 cycles after START
      clr();
      for (int u = 0; u < NU; u++) dly[u] = 2 + u;
      start_run(1, 0, 0);
      wait_idle("stag_idle", 100);
      tick();
      chk("stag_dist", 64'(dist_q[0]), 64'(9));
      chk("stag_no_err", 64'(timeout_err), 64'(0));

      // done only in the START cycle is ignored
      clr(); set_dly(2); dly[3] = 0;
      start_run(1, 0, 0);
      wait_idle("startdone_idle", 100);
      tick();
      chk("startdone_dist", 64'(dist_q[0]), 64'(16));
      chk("startdone_mask", 64'(timeout_mask), 64'(8'h08));

      // randomized runs: delays, level/pulse done, table writes, count changes, aborts
      for (int r = 0; r < 30; r++) begin
         int lim;
         for (int u = 0; u < NU; u++)
            dly[u] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 20));
         lvl = 1'($urandom_range(0, 1));
         start_run(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
         lim = int'($urandom_range(40, 200));
         for (int c = 0; c < lim && busy; c++) begin
            tbl_wen   = ($urandom_range(0, 3) == 0);
            tbl_waddr = AW'($urandom_range(0, 7));
            tbl_wdata = {1'($urandom_range(0, 1)), 32'($urandom())};
            abort     = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 15) == 0) beam_count = (AW+1)'($urandom_range(0, 8));
            if ($urandom_range(0, 15) == 0) loop_en = 1'($urandom_range(0, 1));
            tick();
         end
         tbl_wen = 0;
         abort = busy;
         tick();
         abort = 0;
         tick();
      end

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
